bcd_display_scanner: RTL and testbench



---
 rtl/bcd_display_scanner.sv | 103 ++++++++++
 tb/tb_bcd_display_scanner.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/bcd_display_scanner.sv
// bcd_display_scanner: converts a 16-bit value to four hex or BCD digits and scans them onto a 4-digit 7-segment display
module bcd_display_scanner #(
  parameter int SCAN_DIV = 10000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] value_in,
  input  logic        load,
  input  logic        mode_hex,
  output logic        busy,
  output logic        digits_valid,
  output logic        overflow,
  output logic [3:0]  an,
  output logic [6:0]  cathode
);
  localparam logic [1:0] IDLE = 2'd0, CONVERT = 2'd1, LATCH = 2'd2;
  localparam int PW = $clog2(SCAN_DIV);
  logic [1:0] state;
  logic [15:0] shift;
  logic [19:0] bcd, adj;
  logic [3:0] cnt;
  logic mode;
  logic [3:0][3:0] dig;
  logic [PW-1:0] pre;
  logic [1:0] idx, nidx;
  logic wrap;
  for (genvar i = 0; i < 5; i++) begin : g_adj
    assign adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end
  assign busy = state != IDLE;
  assign wrap = pre == PW'(SCAN_DIV - 1);
  assign nidx = idx + 2'd1;
  function automatic logic [6:0] seg(input logic [3:0] d);
    case (d)
      4'h0: seg = 7'b1000000;
      4'h1: seg = 7'b1111001;
      4'h2: seg = 7'b0100100;
      4'h3: seg = 7'b0110000;
      4'h4: seg = 7'b0011001;
      4'h5: seg = 7'b0010010;
      4'h6: seg = 7'b0000010;
      4'h7: seg = 7'b1111000;
      4'h8: seg = 7'b0000000;
      4'h9: seg = 7'b0010000;
      4'hA: seg = 7'b0001000;
      4'hB: seg = 7'b0000011;
      4'hC: seg = 7'b1000110;
      4'hD: seg = 7'b0100001;
      4'hE: seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  endfunction
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      shift <= '0;
      bcd <= '0;
      cnt <= '0;
      mode <= 1'b0;
      dig <= '0;
      digits_valid <= 1'b0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: if (load) begin
          shift <= value_in;
          mode <= mode_hex;
          bcd <= '0;
          cnt <= '0;
          state <= mode_hex ? LATCH : CONVERT;
        end
        CONVERT: begin
          {bcd, shift} <= {adj, shift} << 1;
          cnt <= cnt + 4'd1;
          if (cnt == 4'd15) state <= LATCH;
        end
        LATCH: begin
          dig <= mode ? shift : bcd[15:0];
          overflow <= !mode && bcd[19:16] != 4'd0;
          digits_valid <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
  // an/cathode change only on prescaler wrap, so a fresh latch shows from the next scan edge
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pre <= '0;
      idx <= '0;
      an <= 4'b1110;
      cathode <= 7'b1111111;
    end else begin
      pre <= wrap ? '0 : pre + 1'b1;
      if (wrap) begin
        idx <= nidx;
        an <= ~(4'b0001 << nidx);
        cathode <= !digits_valid ? 7'b1111111 : overflow ? 7'b0111111 : seg(dig[nidx]);
      end
    end
  end
endmodule

// File: tb/tb_bcd_display_scanner.sv
// tb_bcd_display_scanner: table-driven scoreboard bench for bcd_display_scanner
module tb_bcd_display_scanner;
  localparam int SD = 4;
  logic clk = 0, reset = 0, load = 0, mode_hex = 0;
  logic [15:0] value_in = '0;
  logic busy, digits_valid, overflow;
  logic [3:0] an;
  logic [6:0] cathode;
  int nvec = 0, nerr = 0;
  bcd_display_scanner #(.SCAN_DIV(SD)) dut (
    .clk(clk), .reset(reset), .value_in(value_in), .load(load), .mode_hex(mode_hex),
    .busy(busy), .digits_valid(digits_valid), .overflow(overflow), .an(an), .cathode(cathode)
  );
  always #5 clk = ~clk;
  localparam logic [6:0] SEG [18] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001, 7'b0010010,
    7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110, 7'b0111111, 7'b1111111};
  typedef struct {
    logic [15:0] v;
    logic hex;
    int d3, d2, d1, d0;
    logic ovf;
  } vec_t;
  typedef struct {
    logic [3:0][6:0] seg;
    logic ovf;
    int busy_n;
  } exp_t;
  exp_t q[$];
  vec_t tbl [9];
  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] ex);
    nvec++;
    if (got !== ex) begin
      nerr++;
      $display("FAIL %s: got %0h expected %0h", nm, got, ex);
    end
  endtask
  task automatic do_load(input logic [15:0] v, input logic h, input logic push,
                         input int d3, input int d2, input int d1, input int d0, input logic ov);
    exp_t e;
    @(negedge clk);
    value_in = v;
    mode_hex = h;
    load = 1;
    if (push) begin
      e.seg = {SEG[d3], SEG[d2], SEG[d1], SEG[d0]};
      e.ovf = ov;
      e.busy_n = h ? 1 : 17;
      q.push_back(e);
    end
    @(negedge clk);
    load = 0;
  endtask
  task automatic check_display(input logic [3:0][6:0] s);
    logic [6:0] got [4];
    logic [3:0] seen = '0;
    value_in = ~value_in;
    repeat (4 * SD) @(negedge clk);
    for (int c = 0; c < 4 * SD; c++) begin
      for (int j = 0; j < 4; j++)
        if (an == ~(4'b0001 << j)) begin
          got[j] = cathode;
          seen[j] = 1'b1;
        end
      @(negedge clk);
    end
    chk("slots_seen", {28'd0, seen}, 32'hF);
    for (int j = 0; j < 4; j++) chk($sformatf("digit%0d", j), {25'd0, got[j]}, {25'd0, s[j]});
  endtask
  task automatic wait_done(input int n0);
    int n = n0;
    exp_t e;
    while (busy && n < 60) begin
      n++;
      @(negedge clk);
    end
    if (q.size() == 0) begin
      nvec++;
      nerr++;
      $display("FAIL scoreboard: got empty queue expected entry");
    end else begin
      e = q.pop_front();
      chk("busy_cycles", n, e.busy_n);
      chk("digits_valid", {31'd0, digits_valid}, 1);
      chk("overflow", {31'd0, overflow}, {31'd0, e.ovf});
      check_display(e.seg);
    end
  endtask
  initial begin
    #2_000_000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
  initial begin
    tbl = '{
      '{16'd1234,  1'b0, 1, 2, 3, 4, 1'b0},
      '{16'hBEEF,  1'b1, 11, 14, 14, 15, 1'b0},
      '{16'd10000, 1'b0, 16, 16, 16, 16, 1'b1},
      '{16'd9999,  1'b0, 9, 9, 9, 9, 1'b0},
      '{16'd65535, 1'b0, 16, 16, 16, 16, 1'b1},
      '{16'h00A5,  1'b1, 0, 0, 10, 5, 1'b0},
      '{16'd0,     1'b0, 0, 0, 0, 0, 1'b0},
      '{16'h3C7D,  1'b1, 3, 12, 7, 13, 1'b0},
      '{16'd8090,  1'b0, 8, 0, 9, 0, 1'b0}};
    repeat (2) @(negedge clk);
    chk("rst_busy", {31'd0, busy}, 0);
    chk("rst_valid", {31'd0, digits_valid}, 0);
    chk("rst_ovf", {31'd0, overflow}, 0);
    chk("rst_an", {28'd0, an}, 32'hE);
    chk("rst_cathode", {25'd0, cathode}, 32'h7F);
    @(negedge clk);
    reset = 1;
    for (int e = 1; e <= 4 * SD; e++) begin
      @(negedge clk);
      chk("scan_an", {28'd0, an}, {28'd0, ~(4'b0001 << ((e / SD) % 4))});
      chk("scan_blank", {25'd0, cathode}, 32'h7F);
    end
    foreach (tbl[i]) begin
      do_load(tbl[i].v, tbl[i].hex, 1'b1, tbl[i].d3, tbl[i].d2, tbl[i].d1, tbl[i].d0, tbl[i].ovf);
      wait_done(0);
    end
    do_load(16'd5, 1'b0, 1'b1, 0, 0, 0, 5, 1'b0);
    repeat (4) @(negedge clk);
    value_in = 16'd7;
    load = 1;
    @(negedge clk);
    load = 0;
    wait_done(5);
    chk("no_requeue", {31'd0, busy}, 0);
    do_load(16'd4321, 1'b0, 1'b0, 0, 0, 0, 0, 1'b0);
    repeat (7) @(negedge clk);
    #2 reset = 0;
    #1;
    chk("abort_busy", {31'd0, busy}, 0);
    chk("abort_valid", {31'd0, digits_valid}, 0);
    chk("abort_an", {28'd0, an}, 32'hE);
    chk("abort_cathode", {25'd0, cathode}, 32'h7F);
    @(negedge clk);
    reset = 1;
    do_load(16'd42, 1'b0, 1'b1, 0, 0, 4, 2, 1'b0);
    wait_done(0);
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
